// File: rtl/counter_b4_pkg.sv
// Shared types for the 4-bit multi-mode counter family.
// Mode codes, counter width and monitor states.
package counter_b4_pkg;

  localparam int CNT_W = 4;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_UP3  = 2'b00;
  localparam mode_t MODE_DN1  = 2'b01;
  localparam mode_t MODE_UP1  = 2'b10;
  localparam mode_t MODE_LOAD = 2'b11;

  typedef enum logic [1:0] {
    UNSYNC = 2'd0,
    TRACK  = 2'd1,
    FAIL   = 2'd2
  } mon_state_t;

endpackage

// File: rtl/counter_b4_monitor_if.sv
// Observation bundle between the b4 counter harness and its monitor.
// The master side drives copies of stimulus and counter outputs.
interface counter_b4_monitor_if #(
  parameter int ERR_W = 8
);
  import counter_b4_pkg::*;

  logic             mon_dut_reset;
  logic             mon_enable;
  mode_t            mon_mode;
  logic [CNT_W-1:0] mon_D;
  logic [CNT_W-1:0] mon_Q;
  logic             mon_load;
  logic             mon_rco;

  logic             mon_synced;
  logic [CNT_W-1:0] mon_exp_Q;
  logic             mon_err;
  logic [ERR_W-1:0] mon_err_cnt;
  logic             mon_fail;

  modport master (
    output mon_dut_reset, mon_enable, mon_mode,
    output mon_D, mon_Q, mon_load, mon_rco,
    input  mon_synced, mon_exp_Q, mon_err,
    input  mon_err_cnt, mon_fail
  );

  modport slave (
    input  mon_dut_reset, mon_enable, mon_mode,
    input  mon_D, mon_Q, mon_load, mon_rco,
    output mon_synced, mon_exp_Q, mon_err,
    output mon_err_cnt, mon_fail
  );

endinterface

// File: rtl/counter_b4_model.sv
// Next-value function of the multi-mode counter.
// Pure combinational; width follows CNT_W.
module counter_b4_model
  import counter_b4_pkg::*;
(
  input  logic [CNT_W-1:0] q,
  input  mode_t            mode,
  input  logic [CNT_W-1:0] d,
  input  logic             enable,
  output logic [CNT_W-1:0] nxt_q,
  output logic             nxt_load,
  output logic             nxt_rco
);

  localparam logic [CNT_W-1:0] Q_MAX = '1;
  localparam logic [CNT_W-1:0] Q_UP3 = Q_MAX - CNT_W'(2);

  always_comb begin
    nxt_q    = '0;
    nxt_load = 1'b0;
    nxt_rco  = 1'b0;
    if (enable) begin
      nxt_rco = (q == Q_MAX);
      unique case (mode)
        MODE_UP3: begin
          nxt_q   = q + CNT_W'(3);
          nxt_rco = (q >= Q_UP3);
        end
        MODE_DN1: nxt_q = q - CNT_W'(1);
        MODE_UP1: nxt_q = q + CNT_W'(1);
        MODE_LOAD: begin
          nxt_q    = d;
          nxt_load = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/counter_b4_monitor.sv
// Receive-side checker for the b4 counter: predicts Q/load/rco
// one edge ahead and counts mismatches against the observed outputs.
module counter_b4_monitor
  import counter_b4_pkg::*;
#(
  parameter int ERR_W       = 8,
  parameter bit CHECK_RCO   = 1'b0,
  parameter bit STOP_ON_ERR = 1'b0
) (
  input logic                b4_clk,
  input logic                b4_reset_n,
  counter_b4_monitor_if.slave mon
);

  localparam logic [ERR_W-1:0] CNT_MAX = '1;

  mon_state_t       state;
  mon_state_t       state_nxt;
  logic [CNT_W-1:0] exp_q;
  logic             exp_load;
  logic             exp_rco;
  logic             chk_vld;
  logic [CNT_W-1:0] nxt_q;
  logic             nxt_load;
  logic             nxt_rco;
  logic             err;
  logic             fail;
  logic [ERR_W-1:0] err_cnt;
  logic             cmp_en;
  logic             mism;
  logic             sync_ok;

  counter_b4_model u_model (
    .q        (exp_q),
    .mode     (mon.mon_mode),
    .d        (mon.mon_D),
    .enable   (mon.mon_enable),
    .nxt_q    (nxt_q),
    .nxt_load (nxt_load),
    .nxt_rco  (nxt_rco)
  );

  assign cmp_en = chk_vld && (state == TRACK);

  assign mism = cmp_en &&
    ((mon.mon_Q != exp_q) ||
     (mon.mon_load != exp_load) ||
     (CHECK_RCO && (mon.mon_rco != exp_rco)));

  // Disabled or loading: the next Q is known
  assign sync_ok = !mon.mon_dut_reset &&
    (!mon.mon_enable || (mon.mon_mode == MODE_LOAD));

  always_comb begin
    state_nxt = state;
    unique case (state)
      UNSYNC: if (sync_ok) state_nxt = TRACK;
      TRACK: begin
        if (mon.mon_dut_reset)
          state_nxt = UNSYNC;
        else if (mism && STOP_ON_ERR)
          state_nxt = FAIL;
      end
      FAIL:    state_nxt = FAIL;
      default: state_nxt = UNSYNC;
    endcase
  end

  always_ff @(posedge b4_clk or negedge b4_reset_n) begin
    if (!b4_reset_n) begin
      state    <= UNSYNC;
      exp_q    <= '0;
      exp_load <= 1'b0;
      exp_rco  <= 1'b0;
      chk_vld  <= 1'b0;
      err      <= 1'b0;
      fail     <= 1'b0;
      err_cnt  <= '0;
    end else begin
      state <= state_nxt;
      err   <= mism;
      if (mism) fail <= 1'b1;
      if (mism && (err_cnt != CNT_MAX))
        err_cnt <= err_cnt + ERR_W'(1);
      if (state != FAIL) begin
        if (mon.mon_dut_reset) begin
          exp_load <= 1'b0;
          exp_rco  <= 1'b0;
          chk_vld  <= 1'b0;
        end else if ((state == TRACK) || sync_ok) begin
          exp_q    <= nxt_q;
          exp_load <= nxt_load;
          exp_rco  <= nxt_rco;
          chk_vld  <= 1'b1;
        end else begin
          chk_vld  <= 1'b0;
        end
      end
    end
  end

  assign mon.mon_synced  = (state == TRACK);
  assign mon.mon_exp_Q   = exp_q;
  assign mon.mon_err     = err;
  assign mon.mon_err_cnt = err_cnt;
  assign mon.mon_fail    = fail;

endmodule

// File: tb/tb_counter_b4_monitor.sv
// Bench for counter_b4_monitor: an ideal counter with Q fault
// injection feeds two monitors (rco-checking and stop-on-error).
module tb_counter_b4_monitor;

  logic       b4_clk = 1'b0;
  logic       rst_n  = 1'b1;
  logic       run    = 1'b0;
  logic       dr     = 1'b0;
  logic       en     = 1'b0;
  logic [1:0] md     = 2'd0;
  logic [3:0] dd     = 4'd0;
  logic [3:0] qmask  = 4'd0;
  logic [3:0] cq     = 4'd0;
  logic       cl     = 1'b0;
  logic       cr     = 1'b0;

  int n_chk  = 0;
  int n_fail = 0;

  int chk_rco [2] = '{1, 0};
  int stop_on [2] = '{0, 1};
  int m_state [2] = '{0, 0};
  int m_exp   [2] = '{0, 0};
  int m_eload [2] = '{0, 0};
  int m_erco  [2] = '{0, 0};
  int m_chk   [2] = '{0, 0};
  int m_err   [2] = '{0, 0};
  int m_cnt   [2] = '{0, 0};
  int m_fail  [2] = '{0, 0};

  counter_b4_monitor_if #(.ERR_W(8)) mif0 ();
  counter_b4_monitor_if #(.ERR_W(8)) mif1 ();

  counter_b4_monitor #(
    .ERR_W(8), .CHECK_RCO(1'b1), .STOP_ON_ERR(1'b0)
  ) dut0 (
    .b4_clk(b4_clk), .b4_reset_n(rst_n), .mon(mif0.slave)
  );

  counter_b4_monitor #(
    .ERR_W(8), .CHECK_RCO(1'b0), .STOP_ON_ERR(1'b1)
  ) dut1 (
    .b4_clk(b4_clk), .b4_reset_n(rst_n), .mon(mif1.slave)
  );

  assign mif0.mon_dut_reset = dr;
  assign mif0.mon_enable    = en;
  assign mif0.mon_mode      = md;
  assign mif0.mon_D         = dd;
  assign mif0.mon_Q         = cq ^ qmask;
  assign mif0.mon_load      = cl;
  assign mif0.mon_rco       = cr;
  assign mif1.mon_dut_reset = dr;
  assign mif1.mon_enable    = en;
  assign mif1.mon_mode      = md;
  assign mif1.mon_D         = dd;
  assign mif1.mon_Q         = cq ^ qmask;
  assign mif1.mon_load      = cl;
  assign mif1.mon_rco       = cr;

  always #5 b4_clk = ~b4_clk;

  function automatic int f_q(int q, int e, int m, int d);
    if (e == 0) return 0;
    case (m)
      0:       return (q + 3) % 16;
      1:       return (q + 15) % 16;
      2:       return (q + 1) % 16;
      default: return d;
    endcase
  endfunction

  function automatic int f_rco(int q, int e, int m);
    if (e == 0) return 0;
    if (m == 0) return (q + 3 > 15) ? 1 : 0;
    return (q == 15) ? 1 : 0;
  endfunction

  function automatic int f_load(int e, int m);
    return (e != 0 && m == 3) ? 1 : 0;
  endfunction

  // Ideal counter; synchronous reset gives Q = 0
  always @(posedge b4_clk) begin
    if (dr) begin
      cq <= 4'd0;
      cl <= 1'b0;
      cr <= 1'b0;
    end else begin
      cq <= 4'(f_q(int'(cq), int'(en), int'(md), int'(dd)));
      cl <= 1'(f_load(int'(en), int'(md)));
      cr <= 1'(f_rco(int'(cq), int'(en), int'(md)));
    end
  end

  // Monitor reference: 0 unsynced, 1 tracking, 2 stopped
  always @(posedge b4_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_state[k] = 0; m_exp[k] = 0; m_eload[k] = 0;
        m_erco[k] = 0; m_chk[k] = 0; m_err[k] = 0;
        m_cnt[k] = 0; m_fail[k] = 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        int qo;
        int mis;
        qo  = int'(cq ^ qmask);
        mis = (m_state[k] == 1 && m_chk[k] == 1 &&
               (qo != m_exp[k] || int'(cl) != m_eload[k] ||
                (chk_rco[k] == 1 && int'(cr) != m_erco[k]))) ? 1 : 0;
        m_err[k] = mis;
        if (mis == 1) m_fail[k] = 1;
        if (mis == 1 && m_cnt[k] < 255) m_cnt[k]++;
        if (m_state[k] == 2) begin
        end else if (dr) begin
          m_state[k] = 0; m_eload[k] = 0;
          m_erco[k] = 0; m_chk[k] = 0;
        end else if (m_state[k] == 0 && en && md != 2'd3) begin
          m_chk[k] = 0;
        end else begin
          m_state[k] = (m_state[k] == 1 && mis == 1 &&
                        stop_on[k] == 1) ? 2 : 1;
          m_erco[k]  = f_rco(m_exp[k], int'(en), int'(md));
          m_eload[k] = f_load(int'(en), int'(md));
          m_exp[k]   = f_q(m_exp[k], int'(en), int'(md), int'(dd));
          m_chk[k]   = 1;
        end
      end
    end
  end

  task automatic check(string nm, logic [31:0] act, int exp);
    n_chk++;
    if (act !== 32'(exp)) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic cmp(int k, logic syn, logic [3:0] eq,
                     logic er, logic [7:0] cnt, logic fl);
    check($sformatf("synced%0d", k), 32'(syn),
          (m_state[k] == 1) ? 1 : 0);
    check($sformatf("exp_Q%0d", k), 32'(eq), m_exp[k]);
    check($sformatf("err%0d", k), 32'(er), m_err[k]);
    check($sformatf("err_cnt%0d", k), 32'(cnt), m_cnt[k]);
    check($sformatf("fail%0d", k), 32'(fl), m_fail[k]);
  endtask

  always @(negedge b4_clk) begin
    if (run) begin
      cmp(0, mif0.mon_synced, mif0.mon_exp_Q, mif0.mon_err,
          mif0.mon_err_cnt, mif0.mon_fail);
      cmp(1, mif1.mon_synced, mif1.mon_exp_Q, mif1.mon_err,
          mif1.mon_err_cnt, mif1.mon_fail);
    end
  end

  task automatic step(int r, int e, int m, int d, int msk);
    dr    = 1'(r);
    en    = 1'(e);
    md    = 2'(m);
    dd    = 4'(d);
    qmask = 4'(msk);
    @(negedge b4_clk);
  endtask

  task automatic all_zero(string tag);
    check({tag, "_syn0"}, 32'(mif0.mon_synced), 0);
    check({tag, "_q0"},   32'(mif0.mon_exp_Q), 0);
    check({tag, "_err0"}, 32'(mif0.mon_err), 0);
    check({tag, "_cnt0"}, 32'(mif0.mon_err_cnt), 0);
    check({tag, "_fl0"},  32'(mif0.mon_fail), 0);
    check({tag, "_syn1"}, 32'(mif1.mon_synced), 0);
    check({tag, "_q1"},   32'(mif1.mon_exp_Q), 0);
    check({tag, "_err1"}, 32'(mif1.mon_err), 0);
    check({tag, "_cnt1"}, 32'(mif1.mon_err_cnt), 0);
    check({tag, "_fl1"},  32'(mif1.mon_fail), 0);
  endtask

  initial begin
    #3 rst_n = 1'b0;
    @(negedge b4_clk);
    #1 all_zero("rst");
    @(negedge b4_clk);
    rst_n = 1'b1;
    run   = 1'b1;

    // Load 9 then count up: 9, A, B, C
    step(0, 1, 3, 9, 0);
    repeat (3) step(0, 1, 2, 0, 0);
    check("up1_q", 32'(mif0.mon_exp_Q), 12);
    check("up1_syn", 32'(mif0.mon_synced), 1);

    // Load E then +3 twice: E, 1, 4 (rco on E->1)
    step(0, 1, 3, 14, 0);
    repeat (2) step(0, 1, 0, 0, 0);
    check("up3_q", 32'(mif0.mon_exp_Q), 4);
    step(0, 1, 2, 0, 0);
    check("up3_cnt", 32'(mif0.mon_err_cnt), 0);

    // Counter reset drops sync; enable low resyncs at 0
    step(1, 1, 2, 0, 0);
    check("drst_syn", 32'(mif0.mon_synced), 0);
    step(0, 0, 0, 0, 0);
    check("resync_syn", 32'(mif0.mon_synced), 1);
    check("resync_q", 32'(mif0.mon_exp_Q), 0);
    check("resync_cnt", 32'(mif0.mon_err_cnt), 0);

    // Load 0, count down; counter reports 0 instead of F
    step(0, 1, 3, 0, 0);
    step(0, 1, 1, 0, 0);
    step(0, 1, 2, 0, 15);
    check("mis_err0", 32'(mif0.mon_err), 1);
    check("mis_cnt0", 32'(mif0.mon_err_cnt), 1);
    check("mis_fail0", 32'(mif0.mon_fail), 1);
    check("mis_err1", 32'(mif1.mon_err), 1);
    check("mis_syn1", 32'(mif1.mon_synced), 0);
    step(0, 1, 2, 0, 0);
    check("pulse_end0", 32'(mif0.mon_err), 0);
    check("pulse_cnt0", 32'(mif0.mon_err_cnt), 1);

    // Sustained mismatch saturates the count
    repeat (300) step(0, 1, 2, 0, 1);
    check("sat_cnt0", 32'(mif0.mon_err_cnt), 255);
    check("sat_cnt1", 32'(mif1.mon_err_cnt), 1);
    step(0, 1, 2, 0, 0);

    // Async reset mid-cycle while dut1 is stopped
    #2 rst_n = 1'b0;
    #1 all_zero("arst");
    run = 1'b0;

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule

// File: doc/counter_b4_monitor.md
Name: counter_b4_monitor

Overview:
- Receive-side checker for the 4-bit multi-mode counter (b4_ port family). It observes the stimulus driven into the counter (enable, mode, D, counter reset) and the counter's outputs (Q, load, rco).
- It keeps its own reference model, predicts the next Q/load/rco, flags mismatches and counts them.
- It sits beside the counter in the design/test harness and feeds the pass/fail decision in place of an offline scoreboard.

Parameters:
- ERR_W, 8, width of the saturating error counter.
- CHECK_RCO, 0, 1 = include rco in the compare; 0 = ignore rco.
- STOP_ON_ERR, 0, 1 = enter FAIL on the first mismatch and stop checking.

Ports:
- b4_clk  input  1  single clock; all sampling on posedge.
- b4_reset_n  input  1  asynchronous, active-low reset of the monitor.
- mon_dut_reset  input  1  copy of the counter's synchronous active-high reset.
- mon_enable  input  1  copy of counter enable.
- mon_mode  input  2  copy of counter mode: 00 = +3, 01 = -1, 10 = +1, 11 = load D.
- mon_D  input  4  copy of counter parallel-load data.
- mon_Q  input  4  observed counter Q.
- mon_load  input  1  observed counter load flag.
- mon_rco  input  1  observed counter rco.
- mon_synced  output  1  the model knows the counter value.
- mon_exp_Q  output  4  predicted Q for the current cycle.
- mon_err  output  1  one-cycle pulse on mismatch.
- mon_err_cnt  output  ERR_W  saturating mismatch count.
- mon_fail  output  1  sticky, set on the first mismatch.

Behaviour:
- Async reset (b4_reset_n = 0): state UNSYNC; exp_q = 0; exp_load = 0; exp_rco = 0; chk_vld = 0; mon_err = 0; mon_err_cnt = 0; mon_fail = 0; mon_synced = 0.
- Prediction, registered at every posedge using the values sampled on that edge:
  - dut_reset = 1: exp_load = 0, exp_rco = 0, exp_q unchanged, chk_vld = 0. The counter's Q is undefined here, so go to UNSYNC.
  - enable = 0: exp_q = 0, exp_load = 0, exp_rco = 0.
  - mode 00: exp_q = exp_q + 3 mod 16; exp_rco = 1 iff the old exp_q >= 13.
  - mode 01: exp_q = exp_q - 1 mod 16; exp_rco = 1 iff the old exp_q = 15.
  - mode 10: exp_q = exp_q + 1 mod 16; exp_rco = 1 iff the old exp_q = 15.
  - mode 11: exp_q = D; exp_load = 1; exp_rco = 1 iff the old exp_q = 15.
  - All exp_q arithmetic is 4-bit with wrap-around and no saturation.
- State machine:
  - UNSYNC -> TRACK on any edge with dut_reset = 0 and either enable = 0 or mode = 11; both make the next Q fully defined. chk_vld is set on that edge.
  - All other UNSYNC cycles predict nothing and check nothing.
  - TRACK -> UNSYNC on dut_reset = 1.
  - TRACK -> FAIL on a mismatch when STOP_ON_ERR = 1.
  - FAIL is held until b4_reset_n.
- Compare:
  - Runs on every posedge with chk_vld = 1 and state TRACK.
  - Mismatch = (mon_Q != exp_q) or (mon_load != exp_load) or (CHECK_RCO and mon_rco != exp_rco).
  - The compare uses the prediction registered on the previous edge, so the counter's response to stimulus at edge n is checked at edge n+1.
  - On a mismatch, mon_err is asserted in the following cycle for exactly one cycle.
- mon_err_cnt increments on each mismatch and saturates at 2^ERR_W - 1. It does not wrap.
- mon_fail is set together with the first mon_err and stays set.
- mon_synced = (state == TRACK). mon_exp_Q drives exp_q directly.
- When a mismatch and dut_reset = 1 occur on the same edge, the mismatch is counted before going to UNSYNC.
- b4_reset_n asserted mid-run clears everything immediately, independent of the clock.

Decomposition:
- Shared package counter_b4_pkg holds:
  - Mode encodings: MODE_UP3 = 2'b00, MODE_DN1 = 2'b01, MODE_UP1 = 2'b10, MODE_LOAD = 2'b11.
  - Counter width constant CNT_W = 4.
  - Monitor state encoding: UNSYNC, TRACK, FAIL.
- One natural sub-module, counter_b4_model:
  - Purely combinational next-value function (exp_q, mode, D, enable) -> (nxt_q, nxt_load, nxt_rco).
  - Reusable by later monitors for wider counters.

Test Plan:
- Reset, then enable = 1, mode 11, D = 4'h9 for one cycle, then mode 10 for 3 cycles; a correct counter gives Q = 9, A, B, C -> mon_synced = 1, mon_err never pulses, mon_err_cnt = 0.
- Load D = 4'hE, then mode 00 for 2 cycles; Q = E, 1, 4 -> no error. With CHECK_RCO = 1, exp_rco = 1 on the E->1 step.
- Load D = 4'h0, then mode 01; a faulty counter reports Q = 0 instead of F -> mon_err is a single-cycle pulse one cycle later; mon_err_cnt = 1; mon_fail = 1.
- With STOP_ON_ERR = 0, force mon_Q wrong for 300 consecutive cycles at ERR_W = 8 -> mon_err_cnt saturates at 255.
- After sync, assert mon_dut_reset for 1 cycle -> mon_synced drops and no compare occurs. Then enable = 0 for one cycle -> resync with exp_Q = 0.
- Drop b4_reset_n asynchronously mid-cycle while in FAIL -> all outputs are 0 immediately, without waiting for a clock edge.
